// File: rtl/fx_chain_pipe.sv
// Three-stage clip / volume / ramped-fader chain for NCH packed signed channels.
// Every stage advances on a one-cycle valid strobe; a single clock domain throughout.
module fx_chain_pipe #(
  parameter int DATA_W    = 16,
  parameter int NCH       = 2,
  parameter int GAIN_W    = 8,
  parameter int FADE_STEP = 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  in_valid,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic                  clip_en,
  input  logic [3:0]            clip_lvl,
  input  logic [4:0]            vol,
  input  logic                  fade_en,
  output logic                  out_valid,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [NCH-1:0]        clip_flag,
  output logic [1:0]            fade_state,
  output logic                  fade_done
);

  localparam logic [GAIN_W:0] G_MAX = {1'b1, {GAIN_W{1'b0}}};
  localparam logic [GAIN_W:0] STEP  = (GAIN_W+1)'(FADE_STEP);

  typedef enum logic [1:0] {
    UNITY    = 2'b00,
    FADE_OUT = 2'b01,
    MUTED    = 2'b10,
    FADE_IN  = 2'b11
  } fade_t;

  // Returns {saturated, value}; the window is symmetric about -1/2 so the low limit is ~hi.
  function automatic logic [DATA_W:0] clip_sat(input logic signed [DATA_W-1:0] x,
                                               input logic [3:0] lvl, input logic en);
    logic [4:0]              m;
    logic signed [DATA_W:0]  hi, lo, xe;
    m  = 5'd16 - {1'b0, lvl};
    hi = $signed({1'b0, m, {(DATA_W-5){1'b0}}}) - $signed((DATA_W+1)'(1));
    lo = ~hi;
    xe = {x[DATA_W-1], x};
    clip_sat = {1'b0, x};
    if (en && lvl != 4'd0) begin
      if (xe > hi)      clip_sat = {1'b1, hi[DATA_W-1:0]};
      else if (xe < lo) clip_sat = {1'b1, lo[DATA_W-1:0]};
    end
  endfunction

  function automatic logic signed [DATA_W-1:0] vol_scale(input logic signed [DATA_W-1:0] x,
                                                        input logic [4:0] v);
    logic [4:0]               vc;
    logic signed [DATA_W+5:0] p;
    vc = (v > 5'd16) ? 5'd16 : v;
    p  = (DATA_W+6)'(x) * (DATA_W+6)'($signed({1'b0, vc}));
    vol_scale = DATA_W'(p >>> 4);
  endfunction

  function automatic logic signed [DATA_W-1:0] fade_scale(input logic signed [DATA_W-1:0] y,
                                                         input logic [GAIN_W:0] gain);
    logic signed [DATA_W+GAIN_W+1:0] p;
    p = (DATA_W+GAIN_W+2)'(y) * (DATA_W+GAIN_W+2)'($signed({1'b0, gain}));
    fade_scale = DATA_W'(p >>> GAIN_W);
  endfunction

  logic [NCH*DATA_W-1:0] clip_d, vol_d, fade_d;
  logic [NCH-1:0]        flag_d;
  logic [DATA_W:0]       sat;
  logic [NCH*DATA_W-1:0] x_p0, y_p1;
  logic [NCH-1:0]        flag_p0, flag_p1;
  logic                  vld_p0, vld_p1;
  fade_t                 state, state_d;
  logic [GAIN_W:0]       g, g_d, g_dn, g_up;
  logic                  done_d;

  always_comb begin
    clip_d = '0;
    flag_d = '0;
    vol_d  = '0;
    fade_d = '0;
    sat    = '0;
    for (int c = 0; c < NCH; c++) begin
      sat = clip_sat(in_data[c*DATA_W +: DATA_W], clip_lvl, clip_en);
      clip_d[c*DATA_W +: DATA_W] = sat[DATA_W-1:0];
      flag_d[c]                  = sat[DATA_W];
      vol_d[c*DATA_W +: DATA_W]  = vol_scale(x_p0[c*DATA_W +: DATA_W], vol);
      fade_d[c*DATA_W +: DATA_W] = fade_scale(y_p1[c*DATA_W +: DATA_W], g);
    end
  end

  // Fader: a reversal mid-ramp only flips direction; entering a ramp takes its first step.
  always_comb begin
    state_d = state;
    g_d     = g;
    done_d  = 1'b0;
    g_dn    = (g > STEP) ? g - STEP : '0;
    g_up    = (G_MAX - g > STEP) ? g + STEP : G_MAX;
    if (vld_p1) begin
      if (state == FADE_OUT && !fade_en) begin
        state_d = FADE_IN;
      end else if (state == FADE_IN && fade_en) begin
        state_d = FADE_OUT;
      end else if (fade_en && state != MUTED) begin
        g_d = g_dn;
        if (g_dn == '0) begin
          state_d = MUTED;
          done_d  = 1'b1;
        end else begin
          state_d = FADE_OUT;
        end
      end else if (!fade_en && state != UNITY) begin
        g_d = g_up;
        if (g_up == G_MAX) begin
          state_d = UNITY;
          done_d  = 1'b1;
        end else begin
          state_d = FADE_IN;
        end
      end
    end
  end

  // Stage p0 (clip) and p1 (volume) data: only the strobes need clearing.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      x_p0    <= clip_d;
      flag_p0 <= flag_d;
    end
    if (vld_p0) begin
      y_p1    <= vol_d;
      flag_p1 <= flag_p0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      out_valid <= vld_p1;
    end
  end

  // Stage p2 (fader) outputs and gain state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_data  <= '0;
      clip_flag <= '0;
      fade_done <= 1'b0;
      state     <= UNITY;
      g         <= G_MAX;
    end else begin
      fade_done <= done_d;
      state     <= state_d;
      g         <= g_d;
      if (vld_p1) begin
        out_data  <= fade_d;
        clip_flag <= flag_p1;
      end
    end
  end

  assign fade_state = state;

endmodule

// File: tb/tb_fx_chain_pipe.sv
// Directed and randomized bench for fx_chain_pipe against a per-sample arithmetic model.
module tb_fx_chain_pipe;
  localparam int DATA_W    = 16;
  localparam int NCH       = 2;
  localparam int GAIN_W    = 8;
  localparam int FADE_STEP = 1;
  localparam int G_MAX     = 1 << GAIN_W;
  localparam int ST_UNITY = 0, ST_FADE_OUT = 1, ST_MUTED = 2, ST_FADE_IN = 3;

  logic                  clk = 1'b0;
  logic                  n_rst;
  logic                  in_valid;
  logic [NCH*DATA_W-1:0] in_data;
  logic                  clip_en;
  logic [3:0]            clip_lvl;
  logic [4:0]            vol;
  logic                  fade_en;
  logic                  out_valid;
  logic [NCH*DATA_W-1:0] out_data;
  logic [NCH-1:0]        clip_flag;
  logic [1:0]            fade_state;
  logic                  fade_done;

  fx_chain_pipe #(.DATA_W(DATA_W), .NCH(NCH), .GAIN_W(GAIN_W), .FADE_STEP(FADE_STEP)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_data(in_data),
    .clip_en(clip_en), .clip_lvl(clip_lvl), .vol(vol), .fade_en(fade_en),
    .out_valid(out_valid), .out_data(out_data), .clip_flag(clip_flag),
    .fade_state(fade_state), .fade_done(fade_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                    v;
    logic [NCH*DATA_W-1:0] d;
    bit                    cen;
    int                    lvl;
    int                    vol;
  } ent_t;

  ent_t                  q[$];
  int                    mg, mst;
  logic [NCH*DATA_W-1:0] exp_data;
  logic [NCH-1:0]        exp_flag;
  bit                    exp_valid, exp_done;
  int                    checks = 0;
  int                    errors = 0;
  int                    done_cnt = 0;
  logic [NCH*DATA_W-1:0] pat_a;

  function automatic int floor_div(input int a, input int b);
    int r;
    r = a / b;
    if ((a % b) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  function automatic int ref_clip(input int x, input bit en, input int lvl, output bit f);
    int t;
    t = (16 - lvl) * (1 << (DATA_W - 5)) - 1;
    f = 1'b0;
    if (en && lvl != 0) begin
      if (x > t) begin x = t; f = 1'b1; end
      else if (x < -t - 1) begin x = -t - 1; f = 1'b1; end
    end
    return x;
  endfunction

  function automatic logic [NCH*DATA_W-1:0] rnd_word();
    logic [NCH*DATA_W-1:0] w;
    logic [DATA_W-1:0]     s;
    w = '0;
    for (int c = 0; c < NCH; c++) begin
      case ($urandom_range(0, 5))
        0:       s = {1'b0, {(DATA_W-1){1'b1}}};
        1:       s = {1'b1, {(DATA_W-1){1'b0}}};
        default: s = DATA_W'($urandom);
      endcase
      w[c*DATA_W +: DATA_W] = s;
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    ent_t e;
    e = '{v: 1'b0, d: '0, cen: 1'b0, lvl: 0, vol: 0};
    q.delete();
    q.push_back(e);
    q.push_back(e);
    mg = G_MAX; mst = ST_UNITY;
    exp_data = '0; exp_flag = '0; exp_valid = 1'b0; exp_done = 1'b0;
  endtask

  // Gain moves toward the target picked by fade_en; a ramp heading the other way just turns round.
  task automatic model_fader(output bit done);
    done = 1'b0;
    if (mst == ST_FADE_OUT && !fade_en) mst = ST_FADE_IN;
    else if (mst == ST_FADE_IN && fade_en) mst = ST_FADE_OUT;
    else if (fade_en && mst != ST_MUTED) begin
      mg = (mg - FADE_STEP < 0) ? 0 : mg - FADE_STEP;
      if (mg == 0) begin mst = ST_MUTED; done = 1'b1; end
      else mst = ST_FADE_OUT;
    end else if (!fade_en && mst != ST_UNITY) begin
      mg = (mg + FADE_STEP > G_MAX) ? G_MAX : mg + FADE_STEP;
      if (mg == G_MAX) begin mst = ST_UNITY; done = 1'b1; end
      else mst = ST_FADE_IN;
    end
  endtask

  task automatic model_pop();
    ent_t e;
    bit   f, dn;
    int   x, v, y, o;
    e = q.pop_front();
    exp_valid = e.v;
    exp_done  = 1'b0;
    if (e.v) begin
      for (int c = 0; c < NCH; c++) begin
        x = int'($signed(e.d[c*DATA_W +: DATA_W]));
        x = ref_clip(x, e.cen, e.lvl, f);
        v = (e.vol > 16) ? 16 : e.vol;
        y = floor_div(x * v, 16);
        o = floor_div(y * mg, G_MAX);
        exp_data[c*DATA_W +: DATA_W] = DATA_W'(o);
        exp_flag[c] = f;
      end
      model_fader(dn);
      exp_done = dn;
    end
  endtask

  // One clock: drive at the falling edge, compare at the next falling edge.
  task automatic cyc(input bit v, input logic [NCH*DATA_W-1:0] d);
    ent_t e, p;
    in_valid = v;
    in_data  = d;
    e = '{v: v, d: d, cen: clip_en, lvl: int'(clip_lvl), vol: 0};
    q.push_back(e);
    p = q[q.size()-2];
    p.vol = int'(vol);
    q[q.size()-2] = p;
    @(posedge clk);
    model_pop();
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out_data", 64'(out_data), 64'(exp_data));
    chk("clip_flag", 64'(clip_flag), 64'(exp_flag));
    chk("fade_state", 64'(fade_state), 64'(mst));
    chk("fade_done", 64'(fade_done), 64'(exp_done));
    if (out_valid && fade_done) done_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, rnd_word());
  endtask

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0;
    clip_en = 1'b0; clip_lvl = 4'd0; vol = 5'd16; fade_en = 1'b0;
    pat_a = {NCH{16'h4000}};

    // Reset held: strobes must not reach the output
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_data  = rnd_word();
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_fade_state", 64'(fade_state), 64'd0);
      chk("rst_fade_done", 64'(fade_done), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_rst = 1'b1;
    model_reset();
    cyc(1'b1, {16'd1234, 16'd4321});
    idle(3);

    // Clip at half scale, then clip_lvl=0 passes through
    clip_en = 1'b1; clip_lvl = 4'd8; vol = 5'd16;
    cyc(1'b1, {16'h7000, 16'h9000});
    idle(3);
    chk("clip_half_data", 64'(out_data), 64'({16'h3FFF, 16'hC000}));
    chk("clip_half_flag", 64'(clip_flag), 64'(2'b11));
    clip_lvl = 4'd0;
    cyc(1'b1, {16'h7000, 16'h9000});
    idle(3);
    chk("clip_zero_data", 64'(out_data), 64'({16'h7000, 16'h9000}));
    chk("clip_zero_flag", 64'(clip_flag), 64'(2'b00));

    // Volume with back-to-back strobes
    clip_en = 1'b0; vol = 5'd8;
    for (int i = 0; i < 20; i++) cyc(1'b1, {16'd1000, 16'hFC17});
    idle(3);
    chk("vol_half", 64'(out_data), 64'({16'd500, 16'hFE0B}));
    vol = 5'd20;
    for (int i = 0; i < 5; i++) cyc(1'b1, {16'd1000, 16'hFC17});
    idle(3);
    chk("vol_over", 64'(out_data), 64'({16'd1000, 16'hFC17}));

    // Fade out to mute
    vol = 5'd16; fade_en = 1'b1; done_cnt = 0;
    cyc(1'b1, pat_a); cyc(1'b1, pat_a); cyc(1'b1, pat_a);
    chk("fade_first", 64'(out_data), 64'({NCH{16'h4000}}));
    cyc(1'b1, pat_a);
    chk("fade_second", 64'(out_data), 64'({NCH{16'h3FC0}}));
    chk("fade_ramp_state", 64'(fade_state), 64'd1);
    for (int i = 0; i < 258; i++) cyc(1'b1, pat_a);
    idle(3);
    chk("fade_out_done_cnt", 64'(done_cnt), 64'd1);
    chk("fade_out_state", 64'(fade_state), 64'd2);
    chk("fade_out_data", 64'(out_data), 64'd0);

    // Fade back in from mute, then a reversal at g=156
    fade_en = 1'b0; done_cnt = 0;
    for (int i = 0; i < 256; i++) cyc(1'b1, pat_a);
    idle(3);
    chk("fade_in_state", 64'(fade_state), 64'd0);
    chk("fade_in_done_cnt", 64'(done_cnt), 64'd1);
    fade_en = 1'b1; done_cnt = 0;
    for (int i = 0; i < 100; i++) cyc(1'b1, pat_a);
    idle(3);
    chk("rev_pre_state", 64'(fade_state), 64'd1);
    fade_en = 1'b0;
    cyc(1'b1, pat_a);
    idle(3);
    chk("rev_state", 64'(fade_state), 64'd3);
    chk("rev_gain_out", 64'(out_data), 64'({NCH{16'h2700}}));
    chk("rev_no_done", 64'(done_cnt), 64'd0);
    for (int i = 0; i < 99; i++) cyc(1'b1, pat_a);
    idle(3);
    chk("rev_99_state", 64'(fade_state), 64'd3);
    chk("rev_99_done", 64'(done_cnt), 64'd0);
    cyc(1'b1, pat_a);
    idle(3);
    chk("rev_end_state", 64'(fade_state), 64'd0);
    chk("rev_end_done", 64'(done_cnt), 64'd1);

    // Reset during a ramp with two samples in flight
    fade_en = 1'b1;
    for (int i = 0; i < 52; i++) cyc(1'b1, pat_a);
    #2;
    n_rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_state", 64'(fade_state), 64'd0);
    chk("midrst_flag", 64'(clip_flag), 64'd0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    fade_en = 1'b0;
    model_reset();
    idle(4);
    cyc(1'b1, pat_a);
    idle(3);
    chk("midrst_gain", 64'(out_data), 64'({NCH{16'h4000}}));

    // Randomized traffic, settings and fade direction
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) fade_en = ~fade_en;
      clip_en  = 1'($urandom_range(0, 1));
      clip_lvl = 4'($urandom_range(0, 15));
      vol      = 5'($urandom_range(0, 31));
      cyc($urandom_range(0, 9) < 7, rnd_word());
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
